// File: rtl/syn_fifo_prog.sv
// syn_fifo_prog: single-clock FIFO with fill level, programmable almost-full
// and almost-empty thresholds, sticky error flags, flush and FWFT/registered read.
//
// Ports:
//   i_clk, i_rst_n (async, active-low), i_clr (sync flush)
//   i_wr_en, i_data_in          : write side
//   i_rd_en, o_data_out, o_valid: read side
//   o_full, o_empty, o_almost_full, o_almost_empty, o_count : fill status
//   o_overflow, o_underflow     : sticky error flags
module syn_fifo_prog #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_clr,
  input  logic                       i_wr_en,
  input  logic [WIDTH-1:0]           i_data_in,
  input  logic                       i_rd_en,
  output logic [WIDTH-1:0]           o_data_out,
  output logic                       o_valid,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_almost_full,
  output logic                       o_almost_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overflow,
  output logic                       o_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             ovf;
  logic             unf;
  logic             wr_ok;
  logic             rd_ok;

  // Flags come from the count register only.
  assign o_full         = (count == CW'(DEPTH));
  assign o_empty        = (count == '0);
  assign o_almost_full  = (count >= CW'(AF_THRESH));
  assign o_almost_empty = (count <= CW'(AE_THRESH));
  assign o_count        = count;
  assign o_overflow     = ovf;
  assign o_underflow    = unf;

  // A flush swallows any request in the same cycle.
  assign wr_ok = i_wr_en && !o_full  && !i_clr;
  assign rd_ok = i_rd_en && !o_empty && !i_clr;

  always_ff @(posedge i_clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= i_data_in;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else if (i_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        (wr_ok && !rd_ok): count <= count + 1'b1;
        (rd_ok && !wr_ok): count <= count - 1'b1;
        default:           count <= count;
      endcase
      if (i_wr_en && o_full)  ovf <= 1'b1;
      if (i_rd_en && o_empty) unf <= 1'b1;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign o_data_out = mem[rd_ptr];
    assign o_valid    = !o_empty;
  end else begin : g_reg
    logic [WIDTH-1:0] dout_q;
    logic             valid_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_ok;
        if (rd_ok) dout_q <= mem[rd_ptr];
      end
    end

    assign o_data_out = dout_q;
    assign o_valid    = valid_q;
  end

endmodule

// File: tb/tb_syn_fifo_prog.sv
// tb_syn_fifo_prog: directed bench for syn_fifo_prog, one FWFT
// instance (u1) and one registered-read instance (u0).
module tb_syn_fifo_prog;

  logic       clk;
  int         n_tot;
  int         n_pass;

  logic       rst1_n, clr1, wr1, rd1;
  logic [7:0] d1, q1;
  logic       v1, full1, emp1, af1, ae1, ovf1, unf1;
  logic [4:0] cnt1;

  logic       rst0_n, clr0, wr0, rd0;
  logic [7:0] d0, q0;
  logic       v0, full0, emp0, af0, ae0, ovf0, unf0;
  logic [4:0] cnt0;

  syn_fifo_prog #(.WIDTH(8), .DEPTH(16), .FWFT(1)) u1 (
    .i_clk(clk), .i_rst_n(rst1_n), .i_clr(clr1),
    .i_wr_en(wr1), .i_data_in(d1), .i_rd_en(rd1),
    .o_data_out(q1), .o_valid(v1), .o_full(full1),
    .o_empty(emp1), .o_almost_full(af1),
    .o_almost_empty(ae1), .o_count(cnt1),
    .o_overflow(ovf1), .o_underflow(unf1)
  );

  syn_fifo_prog #(.WIDTH(8), .DEPTH(16), .FWFT(0)) u0 (
    .i_clk(clk), .i_rst_n(rst0_n), .i_clr(clr0),
    .i_wr_en(wr0), .i_data_in(d0), .i_rd_en(rd0),
    .o_data_out(q0), .o_valid(v0), .o_full(full0),
    .o_empty(emp0), .o_almost_full(af0),
    .o_almost_empty(ae0), .o_count(cnt0),
    .o_overflow(ovf0), .o_underflow(unf0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    n_tot = 0; n_pass = 0;
    rst1_n = 0; clr1 = 0; wr1 = 0; rd1 = 0; d1 = 0;
    rst0_n = 0; clr0 = 0; wr0 = 0; rd0 = 0; d0 = 0;
    step(); step();
    rst1_n = 1; rst0_n = 1;
    step();

    // reset state
    chk("rst_cnt", int'(cnt1), 0);
    chk("rst_empty", int'(emp1), 1);
    chk("rst_ae", int'(ae1), 1);
    chk("rst_full", int'(full1), 0);
    chk("rst_af", int'(af1), 0);
    chk("rst_ovf", int'(ovf1), 0);
    chk("rst_unf", int'(unf1), 0);
    chk("rst_valid", int'(v1), 0);
    chk("rst0_valid", int'(v0), 0);
    chk("rst0_dout", int'(q0), 0);

    // fill 1..16
    for (int i = 1; i <= 16; i++) begin
      wr1 = 1; d1 = 8'(i);
      step();
      chk("fill_cnt", int'(cnt1), i);
      chk("fill_ae", int'(ae1), (i <= 2) ? 1 : 0);
      chk("fill_af", int'(af1), (i >= 14) ? 1 : 0);
      chk("fill_full", int'(full1), (i == 16) ? 1 : 0);
    end
    d1 = 8'd17;
    step();
    wr1 = 0;
    chk("ovf_set", int'(ovf1), 1);
    chk("ovf_cnt", int'(cnt1), 16);

    // drain, FWFT data valid in the read cycle
    for (int i = 1; i <= 16; i++) begin
      rd1 = 1;
      chk("drain_valid", int'(v1), 1);
      chk("drain_data", int'(q1), i);
      step();
    end
    chk("drain_cnt", int'(cnt1), 0);
    step();
    rd1 = 0;
    chk("unf_set", int'(unf1), 1);
    chk("unf_cnt", int'(cnt1), 0);
    chk("unf_empty", int'(emp1), 1);
    chk("ovf_sticky", int'(ovf1), 1);

    clr1 = 1;
    step();
    clr1 = 0;
    chk("clr_ovf", int'(ovf1), 0);
    chk("clr_unf", int'(unf1), 0);

    // occupancy 5, then 20 cycles of wr+rd
    for (int i = 0; i < 5; i++) begin
      wr1 = 1; d1 = 8'(100 + i);
      step();
    end
    chk("sim_pre_cnt", int'(cnt1), 5);
    for (int k = 0; k < 20; k++) begin
      wr1 = 1; rd1 = 1; d1 = 8'(105 + k);
      chk("sim_data", int'(q1), 100 + k);
      step();
      chk("sim_cnt", int'(cnt1), 5);
    end
    wr1 = 0;
    for (int k = 0; k < 5; k++) begin
      rd1 = 1;
      chk("sim_tail", int'(q1), 120 + k);
      step();
    end
    rd1 = 0;
    chk("sim_end_cnt", int'(cnt1), 0);
    chk("sim_no_unf", int'(unf1), 0);

    // full with wr+rd
    for (int i = 0; i < 16; i++) begin
      wr1 = 1; d1 = 8'(200 + i);
      step();
    end
    chk("bf_full", int'(full1), 1);
    rd1 = 1; d1 = 8'hEE;
    chk("bf_data", int'(q1), 200);
    step();
    wr1 = 0; rd1 = 0;
    chk("bf_cnt", int'(cnt1), 15);
    chk("bf_ovf", int'(ovf1), 1);
    chk("bf_next", int'(q1), 201);

    clr1 = 1;
    step();
    clr1 = 0;
    chk("clr_cnt", int'(cnt1), 0);

    // empty with wr+rd
    wr1 = 1; rd1 = 1; d1 = 8'd77;
    step();
    rd1 = 0;
    chk("be_cnt", int'(cnt1), 1);
    chk("be_unf", int'(unf1), 1);
    chk("be_data", int'(q1), 77);
    chk("be_valid", int'(v1), 1);

    // flush at count 7, with requests in the same cycle
    for (int i = 0; i < 6; i++) begin
      wr1 = 1; d1 = 8'(i);
      step();
    end
    chk("fl_pre", int'(cnt1), 7);
    clr1 = 1; wr1 = 1; rd1 = 1;
    step();
    clr1 = 0; wr1 = 0; rd1 = 0;
    chk("fl_cnt", int'(cnt1), 0);
    chk("fl_empty", int'(emp1), 1);
    chk("fl_ovf", int'(ovf1), 0);
    chk("fl_unf", int'(unf1), 0);
    chk("fl_valid", int'(v1), 0);

    // registered read mode
    wr0 = 1; d0 = 8'hA5;
    step();
    wr0 = 0;
    chk("r0_cnt", int'(cnt0), 1);
    chk("r0_nv", int'(v0), 0);
    rd0 = 1;
    step();
    rd0 = 0;
    chk("r0_valid", int'(v0), 1);
    chk("r0_data", int'(q0), 8'hA5);
    chk("r0_cnt0", int'(cnt0), 0);
    step();
    chk("r0_pulse", int'(v0), 0);
    chk("r0_hold", int'(q0), 8'hA5);

    // async reset mid-stream
    wr0 = 1; d0 = 8'h3C;
    step();
    d0 = 8'h5A;
    step();
    wr0 = 0; rd0 = 1;
    step();
    rd0 = 0;
    chk("ar_pre_v", int'(v0), 1);
    chk("ar_pre_d", int'(q0), 8'h3C);
    chk("ar_pre_c", int'(cnt0), 1);
    #1 rst0_n = 0;
    #1;
    chk("ar_valid", int'(v0), 0);
    chk("ar_dout", int'(q0), 0);
    chk("ar_cnt", int'(cnt0), 0);
    chk("ar_empty", int'(emp0), 1);
    chk("ar_ae", int'(ae0), 1);
    chk("ar_full", int'(full0), 0);
    step();
    rst0_n = 1;
    step();
    chk("ar_post", int'(cnt0), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
